demux_oht_pipe: RTL and testbench



---
 rtl/demux_oht_pipe_if.sv | 26 ++
 rtl/demux_oht_pipe.sv | 87 ++++++++
 tb/tb_demux_oht_pipe.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_oht_pipe_if.sv
// Stream bundle for the one-hot demultiplexer: one input stream carrying a
// one-hot destination select, and WIDTH independent output channels.
// master = the surrounding logic that feeds and drains the demux,
// slave  = the demux itself.
interface demux_oht_pipe_if #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 4
);
  logic             s_vld;
  logic             s_rdy;
  logic [WIDTH-1:0] s_oht;
  DAT_T             s_dat;
  logic [WIDTH-1:0] m_vld;
  logic [WIDTH-1:0] m_rdy;
  DAT_T             m_dat [WIDTH-1:0];

  modport master (
    output s_vld, s_oht, s_dat, m_rdy,
    input  s_rdy, m_vld, m_dat
  );

  modport slave (
    input  s_vld, s_oht, s_dat, m_rdy,
    output s_rdy, m_vld, m_dat
  );
endinterface

// File: rtl/demux_oht_pipe.sv
// One-hot-addressed stream demultiplexer. Each accepted input transfer is
// written into the one-entry output register of the channel picked by s_oht.
// Selects that are not one-hot are accepted, dropped, flagged on err for one
// cycle and counted in a saturating counter. Only s_rdy is combinational
// (from s_oht and m_rdy); every other output comes straight from a register.
module demux_oht_pipe #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 4,
  parameter int  CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  demux_oht_pipe_if.slave  bus,
  output logic             err,
  output logic [CNT_W-1:0] cnt
);

  logic             sel_ok;
  logic [WIDTH-1:0] chan_free;
  logic             s_rdy_w;
  logic             s_fire;
  logic [WIDTH-1:0] load;
  logic             drop;

  logic [WIDTH-1:0] m_vld_reg;
  DAT_T             m_dat_reg [WIDTH-1:0];
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign sel_ok = $onehot(bus.s_oht);

  // A channel can take a new item if it is empty or its current item leaves
  // this cycle; passing m_rdy through keeps each channel at full throughput.
  assign chan_free = ~m_vld_reg | bus.m_rdy;

  // Bad selects never stall the input: they are swallowed immediately.
  assign s_rdy_w = sel_ok ? |(bus.s_oht & chan_free) : 1'b1;
  assign s_fire  = bus.s_vld & s_rdy_w;
  assign load    = (s_fire && sel_ok) ? bus.s_oht : '0;
  assign drop    = s_fire & ~sel_ok;

  // Per-channel output slot: a load takes priority over the drain so that a
  // simultaneous leave+arrive keeps the slot full with the new item.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_reg <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        m_dat_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (load[i]) begin
          m_vld_reg[i] <= 1'b1;
          m_dat_reg[i] <= bus.s_dat;
        end else if (bus.m_rdy[i]) begin
          m_vld_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Discard reporting: one-cycle pulse plus a counter that sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      err_reg <= drop;
      if (drop && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.s_rdy = s_rdy_w;
  assign bus.m_vld = m_vld_reg;
  assign err       = err_reg;
  assign cnt       = cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_out
      assign bus.m_dat[gi] = m_dat_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_demux_oht_pipe.sv
// Bench for demux_oht_pipe: directed scenarios plus a randomized run, with
// per-channel queues holding the data each channel must deliver next.
module tb_demux_oht_pipe;
  localparam int W = 4;

  logic clk;
  logic rst;

  demux_oht_pipe_if #(.DAT_T(logic [7:0]), .WIDTH(W)) bus_a ();
  demux_oht_pipe_if #(.DAT_T(logic [7:0]), .WIDTH(W)) bus_b ();

  logic       err_a;
  logic [7:0] cnt_a;
  logic       err_b;
  logic [1:0] cnt_b;

  demux_oht_pipe #(.DAT_T(logic [7:0]), .WIDTH(W), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a),
    .err (err_a),
    .cnt (cnt_a)
  );

  demux_oht_pipe #(.DAT_T(logic [7:0]), .WIDTH(W), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b),
    .err (err_b),
    .cnt (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [W][$];
  int         exp_cnt = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] oht,
                       input logic [7:0] dat, input logic [W-1:0] rdy);
    bus_a.s_vld = v;
    bus_a.s_oht = oht;
    bus_a.s_dat = dat;
    bus_a.m_rdy = rdy;
  endtask

  task automatic clear_model;
    for (int c = 0; c < W; c++) exp_q[c].delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, '0, '0, '1);
    bus_b.s_vld = 1'b0;
    bus_b.s_oht = '0;
    bus_b.s_dat = '0;
    bus_b.m_rdy = '1;
    clear_model();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_a.m_vld !== 4'b0000) begin
      n_bad++; $display("FAIL reset_m_vld: got %b want 0000", bus_a.m_vld);
    end
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", err_a);
    end
    n_cmp++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b);
    end
    for (int c = 0; c < W; c++) begin
      n_cmp++;
      if (bus_a.m_dat[c] !== 8'h00) begin
        n_bad++; $display("FAIL reset_m_dat%0d: got %h want 00", c, bus_a.m_dat[c]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_route;
    logic [7:0] e;
    drive(1'b1, 4'b0100, 8'hA5, 4'b1111);
    #1;
    n_cmp++;
    if (bus_a.s_rdy !== 1'b1) begin
      n_bad++; $display("FAIL route_s_rdy: got %b want 1", bus_a.s_rdy);
    end
    exp_q[2].push_back(8'hA5);
    tick();
    drive(1'b0, '0, '0, 4'b1111);
    n_cmp++;
    if (bus_a.m_vld !== 4'b0100) begin
      n_bad++; $display("FAIL route_m_vld: got %b want 0100", bus_a.m_vld);
    end
    e = exp_q[2].pop_front();
    n_cmp++;
    if (bus_a.m_dat[2] !== e) begin
      n_bad++; $display("FAIL route_m_dat2: got %h want %h", bus_a.m_dat[2], e);
    end
    $display("route ch2 out %h", bus_a.m_dat[2]);
    tick();
    n_cmp++;
    if (bus_a.m_vld !== 4'b0000) begin
      n_bad++; $display("FAIL route_drain: got %b want 0000", bus_a.m_vld);
    end
  endtask

  task automatic test_stall;
    logic [7:0] e;
    drive(1'b1, 4'b0010, 8'h11, 4'b0000);
    #1;
    exp_q[1].push_back(8'h11);
    tick();
    drive(1'b1, 4'b0010, 8'h22, 4'b0000);
    #1;
    n_cmp++;
    if (bus_a.s_rdy !== 1'b0) begin
      n_bad++; $display("FAIL stall_s_rdy_full: got %b want 0", bus_a.s_rdy);
    end
    tick();
    n_cmp++;
    if (bus_a.m_dat[1] !== exp_q[1][0]) begin
      n_bad++; $display("FAIL stall_hold1: got %h want %h", bus_a.m_dat[1], exp_q[1][0]);
    end
    drive(1'b1, 4'b1000, 8'h33, 4'b0000);
    #1;
    n_cmp++;
    if (bus_a.s_rdy !== 1'b1) begin
      n_bad++; $display("FAIL stall_s_rdy_other: got %b want 1", bus_a.s_rdy);
    end
    exp_q[3].push_back(8'h33);
    tick();
    drive(1'b0, '0, '0, 4'b0000);
    n_cmp++;
    if (bus_a.m_vld !== 4'b1010) begin
      n_bad++; $display("FAIL stall_m_vld: got %b want 1010", bus_a.m_vld);
    end
    n_cmp++;
    if (bus_a.m_dat[1] !== exp_q[1][0]) begin
      n_bad++; $display("FAIL stall_hold2: got %h want %h", bus_a.m_dat[1], exp_q[1][0]);
    end
    drive(1'b0, '0, '0, 4'b1111);
    #1;
    e = exp_q[1].pop_front();
    n_cmp++;
    if (bus_a.m_dat[1] !== e) begin
      n_bad++; $display("FAIL stall_out1: got %h want %h", bus_a.m_dat[1], e);
    end
    e = exp_q[3].pop_front();
    n_cmp++;
    if (bus_a.m_dat[3] !== e) begin
      n_bad++; $display("FAIL stall_out3: got %h want %h", bus_a.m_dat[3], e);
    end
    $display("stall ch1 out %h, ch3 out %h", bus_a.m_dat[1], bus_a.m_dat[3]);
    tick();
    n_cmp++;
    if (bus_a.m_vld !== 4'b0000) begin
      n_bad++; $display("FAIL stall_drain: got %b want 0000", bus_a.m_vld);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    logic [7:0] d;
    drive(1'b1, 4'b0001, 8'hC3, 4'b0000);
    #1;
    exp_q[0].push_back(8'hC3);
    tick();
    drive(1'b1, 4'b0001, 8'h3C, 4'b0001);
    #1;
    n_cmp++;
    if (bus_a.s_rdy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_pass_s_rdy: got %b want 1", bus_a.s_rdy);
    end
    e = exp_q[0].pop_front();
    n_cmp++;
    if (bus_a.m_dat[0] !== e) begin
      n_bad++; $display("FAIL b2b_old: got %h want %h", bus_a.m_dat[0], e);
    end
    exp_q[0].push_back(8'h3C);
    tick();
    n_cmp++;
    if (bus_a.m_vld[0] !== 1'b1 || bus_a.m_dat[0] !== 8'h3C) begin
      n_bad++; $display("FAIL b2b_replace: got %b/%h want 1/3c", bus_a.m_vld[0], bus_a.m_dat[0]);
    end
    for (int k = 0; k < 8; k++) begin
      d = 8'(8'h10 + k * 8'h11);
      drive(1'b1, 4'b0001, d, 4'b0001);
      #1;
      n_cmp++;
      if (bus_a.s_rdy !== 1'b1 || bus_a.m_vld !== 4'b0001) begin
        n_bad++; $display("FAIL b2b_bubble%0d: got %b/%b want 1/0001", k, bus_a.s_rdy, bus_a.m_vld);
      end
      e = exp_q[0].pop_front();
      n_cmp++;
      if (bus_a.m_dat[0] !== e) begin
        n_bad++; $display("FAIL b2b_data%0d: got %h want %h", k, bus_a.m_dat[0], e);
      end
      $display("b2b ch0 out %h", bus_a.m_dat[0]);
      exp_q[0].push_back(d);
      tick();
    end
    drive(1'b0, '0, '0, 4'b0001);
    e = exp_q[0].pop_front();
    n_cmp++;
    if (bus_a.m_vld !== 4'b0001 || bus_a.m_dat[0] !== e) begin
      n_bad++; $display("FAIL b2b_last: got %b/%h want 0001/%h", bus_a.m_vld, bus_a.m_dat[0], e);
    end
    tick();
    n_cmp++;
    if (bus_a.m_vld !== 4'b0000) begin
      n_bad++; $display("FAIL b2b_drain: got %b want 0000", bus_a.m_vld);
    end
  endtask

  task automatic test_discard;
    drive(1'b1, 4'b0000, 8'hEE, 4'b1111);
    #1;
    n_cmp++;
    if (bus_a.s_rdy !== 1'b1) begin
      n_bad++; $display("FAIL disc_zero_s_rdy: got %b want 1", bus_a.s_rdy);
    end
    exp_cnt++;
    tick();
    n_cmp++;
    if (err_a !== 1'b1 || cnt_a !== 8'(exp_cnt) || bus_a.m_vld !== 4'b0000) begin
      n_bad++; $display("FAIL disc_zero: got err=%b cnt=%0d vld=%b want 1/%0d/0000", err_a, cnt_a, bus_a.m_vld, exp_cnt);
    end
    drive(1'b1, 4'b0110, 8'hDD, 4'b1111);
    #1;
    n_cmp++;
    if (bus_a.s_rdy !== 1'b1) begin
      n_bad++; $display("FAIL disc_multi_s_rdy: got %b want 1", bus_a.s_rdy);
    end
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, 4'b1111);
    n_cmp++;
    if (err_a !== 1'b1 || cnt_a !== 8'(exp_cnt) || bus_a.m_vld !== 4'b0000) begin
      n_bad++; $display("FAIL disc_multi: got err=%b cnt=%0d vld=%b want 1/%0d/0000", err_a, cnt_a, bus_a.m_vld, exp_cnt);
    end
    tick();
    n_cmp++;
    if (err_a !== 1'b0 || cnt_a !== 8'(exp_cnt)) begin
      n_bad++; $display("FAIL disc_idle: got err=%b cnt=%0d want 0/%0d", err_a, cnt_a, exp_cnt);
    end
  endtask

  task automatic test_saturate;
    int want;
    for (int k = 1; k <= 5; k++) begin
      bus_b.s_vld = 1'b1;
      bus_b.s_oht = '0;
      bus_b.s_dat = 8'(k);
      #1;
      n_cmp++;
      if (bus_b.s_rdy !== 1'b1) begin
        n_bad++; $display("FAIL sat_s_rdy%0d: got %b want 1", k, bus_b.s_rdy);
      end
      tick();
      want = (k > 3) ? 3 : k;
      n_cmp++;
      if (cnt_b !== 2'(want) || err_b !== 1'b1) begin
        n_bad++; $display("FAIL sat_cnt%0d: got cnt=%0d err=%b want %0d/1", k, cnt_b, err_b, want);
      end
    end
    bus_b.s_vld = 1'b0;
  endtask

  task automatic test_async_reset;
    for (int c = 0; c < W; c++) begin
      drive(1'b1, 4'(1 << c), 8'(8'h50 + c), 4'b0000);
      exp_q[c].push_back(8'(8'h50 + c));
      tick();
    end
    drive(1'b1, 4'b0000, 8'h00, 4'b0000);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, 4'b0000);
    n_cmp++;
    if (bus_a.m_vld !== 4'b1111 || err_a !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre: got vld=%b err=%b want 1111/1", bus_a.m_vld, err_a);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus_a.m_vld !== 4'b0000 || err_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_bad++; $display("FAIL arst_clear: got vld=%b err=%b cnt=%0d/%0d want 0000/0/0/0", bus_a.m_vld, err_a, cnt_a, cnt_b);
    end
    for (int c = 0; c < W; c++) begin
      n_cmp++;
      if (bus_a.m_dat[c] !== 8'h00) begin
        n_bad++; $display("FAIL arst_m_dat%0d: got %h want 00", c, bus_a.m_dat[c]);
      end
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    test_route();
  endtask

  task automatic test_random;
    logic exp_err;
    exp_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] rdy;
      logic [W-1:0] oht;
      logic [W-1:0] mv;
      logic         v;
      logic         ok;
      logic         erdy;
      logic [7:0]   d;
      logic [7:0]   e;
      rdy = W'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) oht = W'($urandom);
      else                           oht = W'(1) << $urandom_range(0, W - 1);
      d = 8'($urandom);
      for (int c = 0; c < W; c++) mv[c] = (exp_q[c].size() != 0);
      n_cmp++;
      if (bus_a.m_vld !== mv || err_a !== exp_err || cnt_a !== 8'(exp_cnt)) begin
        n_bad++; $display("FAIL rnd_state%0d: got vld=%b err=%b cnt=%0d want %b/%b/%0d", n, bus_a.m_vld, err_a, cnt_a, mv, exp_err, exp_cnt);
      end
      drive(v, oht, d, rdy);
      #1;
      ok   = $onehot(oht);
      erdy = 1'b1;
      if (ok) begin
        for (int c = 0; c < W; c++) begin
          if (oht[c]) erdy = !mv[c] || rdy[c];
        end
      end
      n_cmp++;
      if (bus_a.s_rdy !== erdy) begin
        n_bad++; $display("FAIL rnd_s_rdy%0d: got %b want %b (oht=%b rdy=%b)", n, bus_a.s_rdy, erdy, oht, rdy);
      end
      for (int c = 0; c < W; c++) begin
        if (mv[c] && rdy[c]) begin
          e = exp_q[c].pop_front();
          n_cmp++;
          if (bus_a.m_dat[c] !== e) begin
            n_bad++; $display("FAIL rnd_data%0d_ch%0d: got %h want %h", n, c, bus_a.m_dat[c], e);
          end
          $display("rnd ch%0d out %h", c, bus_a.m_dat[c]);
        end
      end
      exp_err = 1'b0;
      if (v && erdy) begin
        if (ok) begin
          for (int c = 0; c < W; c++) begin
            if (oht[c]) exp_q[c].push_back(d);
          end
        end else begin
          exp_err = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
      tick();
    end
    drive(1'b0, '0, '0, '1);
  endtask

  initial begin
    test_reset();
    test_route();
    test_stall();
    test_back_to_back();
    test_discard();
    test_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
